// File: rtl/uart_pkg.sv
// Shared UART receive definitions: sequencer states and default timebase constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_DIVISOR    = 27;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } rx_state_t;

    // Even parity: the XOR of the data bits must equal the transmitted parity bit.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small elastic buffer for received bytes with a registered head output.
// A push into a full buffer is dropped unless a pop happens on the same clock.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop_req,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_req & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_nxt  = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & full & ~do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Head follows the next stored entry on pop, or the incoming byte
            // when that byte becomes the only entry.
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_q <= mem[rd_nxt];
                end else if (do_push) begin
                    head_q <= din;
                end
            end else if (do_push && empty) begin
                head_q <= din;
            end
        end
    end

    assign dout  = head_q;
    assign valid = ~empty;
    assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizer, oversampling timebase, frame sequencer and byte buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit after the eighth data bit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, counters held at 0, waiting for rx_s low
// START      | start bit seen, re-checked at mid-bit to reject glitches
// DATA       | eight data bits sampled at mid-bit, LSB first
// PARITY     | even-parity bit sampled at mid-bit (UART_RX_PARITY_EN only)
// STOP       | stop bit sampled: high pushes the byte, low flags framing
// WAIT_IDLE  | after a framing error, wait for the line to return high
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIVISOR    = DEFAULT_DIVISOR,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_serial,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PSW = $clog2(DIVISOR);
    localparam int SSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  rx_meta;
    logic                  rx_s;
    logic [PSW-1:0]        presc;
    logic [SSW-1:0]        samp;
    logic                  tick;
    logic                  mid;
    logic [BW-1:0]         bit_idx;
    logic                  last_bit;
    logic [DATA_BITS-1:0]  shifter;
    logic                  byte_ok;
    logic                  push;
    logic                  frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_d;
    logic                  par_bad;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // Timebase is parked at zero whenever no frame is in progress, so a frame
    // always starts its bit timing from the start-detection clock.
    assign tick     = (presc == PSW'(DIVISOR - 1));
    assign mid      = tick && (samp == SSW'(OVERSAMPLE / 2 - 1));
    assign last_bit = (bit_idx == BW'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            samp  <= '0;
        end else if (state == ST_IDLE || state == ST_WAIT_IDLE) begin
            presc <= '0;
            samp  <= '0;
        end else if (tick) begin
            presc <= '0;
            samp  <= (samp == SSW'(OVERSAMPLE - 1)) ? '0 : samp + SSW'(1);
        end else begin
            presc <= presc + PSW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_nxt = ST_START;
            ST_START:     if (mid) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      if (mid && last_bit) state_nxt = ST_PARITY;
            ST_PARITY:    if (mid) state_nxt = ST_STOP;
`else
            ST_DATA:      if (mid && last_bit) state_nxt = ST_STOP;
`endif
            ST_STOP:      if (mid) state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign byte_ok = ~par_bad;
`else
    assign byte_ok = 1'b1;
`endif

    always_comb begin
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state)
            ST_STOP: begin
                if (mid) begin
                    push        = rx_s & byte_ok;
                    frame_err_d = ~rx_s;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid) begin
                    parity_err_d = even_parity(shifter) ^ rx_s;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx <= '0;
            shifter <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                ST_START: begin
                    if (mid) begin
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shifter <= {rx_s, shifter[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        par_bad <= parity_err_d;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (shifter),
        .pop_req (data_ready),
        .dout    (data_out),
        .valid   (data_valid),
        .count   (fifo_count),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl at 4 clocks/tick, 16 ticks/bit, 4-entry buffer.
// Builds with or without UART_RX_PARITY_EN; parity cases run only when it is defined.
module tb_uart_rx_ctrl;

    localparam int DIV   = 4;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int BIT   = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Clocks from the first start-bit clock edge to the edge that pushes the byte:
    // 2 synchronizer + 1 state edge, half a bit of ticks, then the remaining bits.
    localparam int VIS = 3 + DIV * (OS / 2) + BIT * (FRAME_BITS - 1);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [2:0] fifo_count;

    uart_rx_ctrl #(
        .DIVISOR    (DIV),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_serial  (rx_serial),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int ferr_n = 0;
    int perr_n = 0;
    int ovr_n  = 0;
    int val_n  = 0;
    int pop_n  = 0;
    logic [7:0] pop_log [512];

    // Pulse counters count high cycles, so a two-cycle pulse shows as 2.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err)  ferr_n++;
            if (parity_err) perr_n++;
            if (overrun)    ovr_n++;
            if (data_valid) val_n++;
            if (data_valid && data_ready) begin
                pop_log[pop_n] = data_out;
                pop_n++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        return {stop, par, d, 1'b0};
`else
        return {par, stop, d, 1'b0};
`endif
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        logic [10:0] f;
        f = mk_frame(d, stop, par);
        @(posedge clk);
        #1;
        for (int i = 0; i < FRAME_BITS; i++) drive_bit(f[i]);
        rx_serial = 1'b1;
    endtask

    task automatic fill(input int n);
        for (int k = 1; k <= n; k++) begin
            send_frame(8'(k), 1'b1, ^(8'(k)));
            idle(BIT / 2);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rx;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_ferr, b_perr, b_ovr, b_val, b_pop;
        logic [7:0] abort_d;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h11, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 1, 0};
        vecs[6] = '{8'hC3, 1'b0, 0, 1};
        vecs[7] = '{8'h5A, 1'b1, 1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out",   int'(data_out),   0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_frame_err",  int'(frame_err),  0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_overrun",    int'(overrun),    0);
        check("rst_fifo_count", int'(fifo_count), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(BIT);

        // Exact byte-visible latency with the consumer stalled.
        data_ready = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, ^(8'hA5));
            begin
                repeat (VIS) @(posedge clk);
                @(negedge clk);
                check("lat_valid_before", int'(data_valid), 0);
                @(posedge clk);
                @(negedge clk);
                check("lat_valid_after", int'(data_valid), 1);
                check("lat_data_out", int'(data_out), 'hA5);
            end
        join
        idle(BIT / 2);
        check("lat_count", int'(fifo_count), 1);
        b_pop = pop_n;
        data_ready = 1'b1;
        idle(4);
        check("lat_pop_n", pop_n - b_pop, 1);
        check("lat_pop_val", int'(pop_log[b_pop]), 'hA5);
        check("lat_count_drained", int'(fifo_count), 0);

        for (int i = 0; i < 8; i++) begin
            b_ferr = ferr_n; b_perr = perr_n; b_ovr = ovr_n; b_val = val_n; b_pop = pop_n;
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
            idle(BIT);
            check($sformatf("vec%0d_rx", i),    pop_n - b_pop,  vecs[i].exp_rx);
            check($sformatf("vec%0d_valid", i), val_n - b_val,  vecs[i].exp_rx);
            check($sformatf("vec%0d_ferr", i),  ferr_n - b_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr", i),  perr_n - b_perr, 0);
            check($sformatf("vec%0d_ovr", i),   ovr_n - b_ovr,  0);
            check($sformatf("vec%0d_count", i), int'(fifo_count), 0);
            if (vecs[i].exp_rx != 0)
                check($sformatf("vec%0d_data", i), int'(pop_log[b_pop]), int'(vecs[i].data));
        end

        // Start glitch shorter than half a bit.
        b_ferr = ferr_n; b_val = val_n; b_pop = pop_n;
        @(posedge clk);
        #1 rx_serial = 1'b0;
        idle(20);
        rx_serial = 1'b1;
        idle(2 * BIT);
        check("glitch_pop",   pop_n - b_pop,  0);
        check("glitch_valid", val_n - b_val,  0);
        check("glitch_ferr",  ferr_n - b_ferr, 0);
        check("glitch_count", int'(fifo_count), 0);
        b_pop = pop_n;
        send_frame(8'h6E, 1'b1, ^(8'h6E));
        idle(BIT);
        check("glitch_next_pop", pop_n - b_pop, 1);
        check("glitch_next_data", int'(pop_log[b_pop]), 'h6E);

        // Overrun on the fifth byte with the consumer stalled.
        data_ready = 1'b0;
        b_ovr = ovr_n;
        fill(4);
        check("ovr_count4", int'(fifo_count), 4);
        check("ovr_none_yet", ovr_n - b_ovr, 0);
        send_frame(8'h05, 1'b1, ^(8'h05));
        idle(BIT / 2);
        check("ovr_pulse", ovr_n - b_ovr, 1);
        check("ovr_count_hold", int'(fifo_count), 4);
        check("ovr_head", int'(data_out), 1);
        b_pop = pop_n;
        data_ready = 1'b1;
        idle(8);
        check("ovr_drain_n", pop_n - b_pop, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("ovr_drain%0d", k), int'(pop_log[b_pop + k]), k + 1);

        // Full buffer, pop on the same clock as the fifth push.
        data_ready = 1'b0;
        fill(4);
        check("sim_count4", int'(fifo_count), 4);
        b_ovr = ovr_n; b_pop = pop_n;
        fork
            send_frame(8'h05, 1'b1, ^(8'h05));
            begin
                repeat (VIS) @(posedge clk);
                #1 data_ready = 1'b1;
                @(posedge clk);
                #1 data_ready = 1'b0;
            end
        join
        idle(BIT / 2);
        check("sim_no_ovr", ovr_n - b_ovr, 0);
        check("sim_count", int'(fifo_count), 4);
        check("sim_pop1", int'(pop_log[b_pop]), 1);
        data_ready = 1'b1;
        idle(8);
        check("sim_drain_n", pop_n - b_pop, 5);
        check("sim_last", int'(pop_log[b_pop + 4]), 5);

        // Reset in the middle of bit 4 with one byte buffered.
        data_ready = 1'b0;
        send_frame(8'h77, 1'b1, ^(8'h77));
        idle(BIT / 2);
        check("rstmid_count_pre", int'(fifo_count), 1);
        abort_d = 8'h33;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(abort_d[i]);
        rx_serial = abort_d[4];
        idle(BIT / 2);
        reset_n = 1'b0;
        rx_serial = 1'b1;
        idle(2);
        @(negedge clk);
        check("rstmid_valid", int'(data_valid), 0);
        check("rstmid_count", int'(fifo_count), 0);
        check("rstmid_data",  int'(data_out),   0);
        check("rstmid_ferr",  int'(frame_err),  0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2 * BIT);
        b_pop = pop_n; b_ferr = ferr_n;
        data_ready = 1'b1;
        send_frame(8'h5A, 1'b1, ^(8'h5A));
        idle(BIT);
        check("rstmid_next_pop", pop_n - b_pop, 1);
        check("rstmid_next_data", int'(pop_log[b_pop]), 'h5A);
        check("rstmid_next_ferr", ferr_n - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
        b_pop = pop_n; b_perr = perr_n;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT);
        check("par_ok_pop", pop_n - b_pop, 1);
        check("par_ok_data", int'(pop_log[b_pop]), 'h07);
        check("par_ok_perr", perr_n - b_perr, 0);
        b_pop = pop_n; b_perr = perr_n; b_ferr = ferr_n;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(BIT);
        check("par_bad_pop", pop_n - b_pop, 0);
        check("par_bad_perr", perr_n - b_perr, 1);
        check("par_bad_ferr", ferr_n - b_ferr, 0);
        check("par_bad_count", int'(fifo_count), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
